// File: rtl/or1200_dc_biu_burst.sv
// or1200_dc_biu_burst: Wishbone B3 master sequencer for the data cache.
// It turns single/burst read and write requests from the cache FSM into bus
// cycles. It handles wrap addressing, beat counting, retry and turnaround.
// Optional feature macro: OR1200_DC_BIU_BURST_EN. When it is defined, bursts
// are issued as wrapping incrementing bursts (cti 010/111, bte 01). When it is
// undefined, bursts run as back-to-back classic cycles with cti 000 and bte 00.
module or1200_dc_biu_burst #(
    parameter int BEATS = 4,
    parameter int AW    = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [AW-1:0]             dc_addr,
    input  logic [3:0]                dc_sel,
    input  logic [31:0]               dc_dat_i,
    input  logic                      biu_read,
    input  logic                      biu_write,
    input  logic                      burst,
    output logic                      biudata_valid,
    output logic                      biudata_error,
    output logic [31:0]               biu_dat_o,
    output logic [$clog2(BEATS)-1:0]  beat_idx,
    output logic                      busy,
    output logic                      wb_cyc_o,
    output logic                      wb_stb_o,
    output logic                      wb_we_o,
    output logic [AW-1:0]             wb_adr_o,
    output logic [3:0]                wb_sel_o,
    output logic [31:0]               wb_dat_o,
    output logic [2:0]                wb_cti_o,
    output logic [1:0]                wb_bte_o,
    input  logic                      wb_ack_i,
    input  logic                      wb_err_i,
    input  logic                      wb_rty_i,
    input  logic [31:0]               wb_dat_i
);

    localparam int IW = $clog2(BEATS);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SINGLE = 3'd1,
        ST_BURST  = 3'd2,
        ST_RETRY  = 3'd3,
        ST_TURN   = 3'd4
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [IW-1:0]   cnt_r;
    logic [IW-1:0]   cnt_s;
    logic            ret_burst_r;
    logic            ret_burst_s;
    logic [AW-1:0]   adr_s;
    logic            we_s;
    logic [3:0]      sel_s;
    logic            cyc_s;
    logic [2:0]      cti_s;
    logic [1:0]      bte_s;
    logic            busy_s;
    logic            unused_addr_s;

    // The low address bits select bytes via dc_sel; the word address drops them.
    assign unused_addr_s = ^dc_addr[1:0];

    // Next-state and next-output decode. The bus controls are computed from the
    // next state so that they come straight out of flops.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        ret_burst_s = ret_burst_r;
        adr_s       = wb_adr_o;
        we_s        = wb_we_o;
        sel_s       = wb_sel_o;
        case (state_r)
            ST_IDLE: begin
                if (biu_read || biu_write) begin
                    we_s        = ~biu_read;
                    adr_s       = {dc_addr[AW-1:2], 2'b00};
                    sel_s       = burst ? 4'hF : dc_sel;
                    ret_burst_s = burst;
                    if (burst) begin
                        state_s = ST_BURST;
                        cnt_s   = IW'(BEATS - 1);
                    end else begin
                        state_s = ST_SINGLE;
                        cnt_s   = '0;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SINGLE: begin
                if (wb_ack_i || wb_err_i) begin
                    state_s = ST_TURN;
                end else if (wb_rty_i) begin
                    state_s = ST_RETRY;
                end else begin
                    state_s = ST_SINGLE;
                end
            end
            ST_BURST: begin
                if (wb_ack_i) begin
                    // Wrap within the line: only the word-index bits advance.
                    adr_s[IW+1:2] = wb_adr_o[IW+1:2] + IW'(1);
                    if (cnt_r == '0) begin
                        state_s = ST_TURN;
                    end else begin
                        cnt_s = cnt_r - IW'(1);
                    end
                end else if (wb_err_i) begin
                    state_s = ST_TURN;
                end else if (wb_rty_i) begin
                    state_s = ST_RETRY;
                end else begin
                    state_s = ST_BURST;
                end
            end
            ST_RETRY: begin
                // Reissue the same beat: address and counter were left untouched.
                state_s = ret_burst_r ? ST_BURST : ST_SINGLE;
            end
            ST_TURN: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        cyc_s  = (state_s == ST_SINGLE) || (state_s == ST_BURST);
        busy_s = (state_s != ST_IDLE);
        cti_s  = 3'b000;
        bte_s  = 2'b00;
        if (state_s == ST_BURST) begin
`ifdef OR1200_DC_BIU_BURST_EN
            cti_s = (cnt_s == '0) ? 3'b111 : 3'b010;
            bte_s = 2'b01;
`else
            cti_s = 3'b000;
            bte_s = 2'b00;
`endif
        end else begin
            cti_s = 3'b000;
            bte_s = 2'b00;
        end
    end

    // State, beat counter and all registered Wishbone controls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            ret_burst_r <= 1'b0;
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            wb_we_o     <= 1'b0;
            wb_adr_o    <= '0;
            wb_sel_o    <= 4'h0;
            wb_cti_o    <= 3'b000;
            wb_bte_o    <= 2'b00;
            busy        <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            ret_burst_r <= ret_burst_s;
            wb_cyc_o    <= cyc_s;
            wb_stb_o    <= cyc_s;
            wb_we_o     <= we_s;
            wb_adr_o    <= adr_s;
            wb_sel_o    <= sel_s;
            wb_cti_o    <= cti_s;
            wb_bte_o    <= bte_s;
            busy        <= busy_s;
        end
    end

    // Beat pulses are combinational so the cache sees the slave's termination
    // in the same cycle. Ack outranks err when both are asserted.
    assign biudata_valid = wb_ack_i & wb_cyc_o & wb_stb_o;
    assign biudata_error = wb_err_i & ~wb_ack_i & wb_cyc_o & wb_stb_o;
    assign biu_dat_o     = wb_dat_i;
    assign wb_dat_o      = wb_we_o ? dc_dat_i : 32'h0000_0000;
    assign beat_idx      = wb_adr_o[IW+1:2];

endmodule
